instr_mem_loader: RTL
=====================

// Module: instr_mem_loader
// PURPOSE
//  Write-side counterpart of the instruction ROM. Receives a byte-stream program image (host/UART
//  side) with a valid/ready handshake, packs bytes into 32-bit words, and writes them into the
//  instruction RAM through a word write port.
//  While loading, CpuHold keeps the pipeline frozen; Done flags a complete image.
// PARAMETERS
//  DEPTH      256    instruction words addressable; the RAM is indexed by MemAddr[9:2]
//  BASE_ADDR  32'h0  byte address of word 0; must be word-aligned
// PORTS
//  clk         in   1   system clock, rising edge
//  reset       in   1   asynchronous, active-low reset
//  Start       in   1   one-cycle pulse; begins a load (honoured only in IDLE/DONE/ERR)
//  ByteValid   in   1   ByteData is valid
//  ByteData    in   8   stream byte
//  ByteReady   out  1   loader accepts a byte this cycle (transfer = ByteValid & ByteReady)
//  MemWrEn     out  1   one-cycle instruction-RAM write strobe
//  MemAddr     out  32  byte address of the write (word-aligned)
//  MemWrData   out  32  instruction word
//  CpuHold     out  1   1 while loading; pipeline held in reset/stall
//  Done        out  1   sticky; image fully written
//  Error       out  1   sticky; bad count (or checksum); cleared by Start
// BEHAVIOUR
//  - Reset values: ByteReady=0, MemWrEn=0, MemAddr=BASE_ADDR, MemWrData=0, CpuHold=0, Done=0,
//    Error=0. FSM=IDLE; word index and byte lane cleared.
//  - Frame format: N[7:0], N[15:8], then N words, each sent as 4 bytes little-endian
//    (byte0 -> [7:0] ... byte3 -> [31:24]).
//  - FSM: IDLE -Start-> HDR0 -xfer-> HDR1 -xfer->
//      HDR1 exit: N==0 -> DONE; N>DEPTH -> ERR; otherwise -> DATA.
//      DATA -> DONE after the last word's write, or -> CSUM when CHECKSUM_EN is defined.
//    DONE/ERR -Start-> HDR0. Start in any other state is ignored.
//    Start clears Done and Error and resets the word index to 0.
//  - ByteReady=1 in HDR0, HDR1 and DATA (and CSUM), except in the cycle MemWrEn is asserted.
//    Zero-wait: one byte per cycle is sustainable apart from that one bubble per word.
//  - On the 4th byte transfer of word k: the next cycle MemWrEn=1, MemWrData=word,
//    MemAddr = BASE_ADDR + 4*k.
//  - MemAddr/MemWrData hold their values after the strobe; the index wraps only via Start.
//  - CpuHold=1 from the cycle after Start until the cycle DONE/ERR is entered (inclusive of the
//    last write); 0 otherwise.
//  - Done and Error are never both 1.
//  - Reset mid-load: immediate return to IDLE; the partial word is discarded; RAM contents are
//    untouched by the loader.
//  - Start coincident with ByteValid in DONE: the byte is not consumed (ByteReady=0 that cycle).
// CONFIGURATION
//  CHECKSUM_EN defined: after the last word, one extra byte is expected in state CSUM.
//    Its value = XOR of all preceding frame bytes, header included.
//    Match -> DONE; mismatch -> ERR. Words are already written either way.
//  Not defined: no CSUM state; DATA goes directly to DONE; Error is only set by N>DEPTH.
// STRUCTURE
//  Package instr_loader_pkg:
//    - state encoding localparams (IDLE, HDR0, HDR1, DATA, CSUM, DONE, ERR)
//    - WORD_W=32, BYTE_W=8
//    - frame header width 16
//  Sub-module word_assembler: 2-bit byte lane counter plus 32-bit shift/pack register.
//    Inputs: byte + strobe; outputs word_valid pulse + word; clear input driven by Start/reset.
//  Top level: FSM, word index counter, count compare, checksum accumulator (ifdef), output regs.
// TESTING
//  1. Frame N=2, words 0x20040005, 0x00001026, no gaps -> writes (0x0,0x20040005) and
//     (0x4,0x00001026); Done=1; CpuHold falls.
//  2. Same frame with ByteValid toggling randomly -> identical writes; no byte lost or duplicated.
//  3. Header N=0 -> no MemWrEn; Done=1 two transfers after Start; N=257 with DEPTH=256 -> Error=1,
//     ByteReady=0.
//  4. Reset asserted after 6 of 8 payload bytes -> all outputs at reset values.
//     New Start + full frame -> writes from index 0.
//  5. Start pulsed during DATA -> ignored; Start in DONE -> Done clears, new frame loads at BASE_ADDR.
//  6. CHECKSUM_EN: correct XOR byte -> Done=1; corrupted byte -> Error=1, both words still written.

Source files
------------

// File: rtl/instr_mem_loader_pkg.sv
// Shared types and constants for the instruction memory loader.
// Optional checksum byte is enabled by defining CHECKSUM_EN.
package instr_loader_pkg;

  localparam int WORD_W = 32;
  localparam int BYTE_W = 8;
  localparam int HDR_W  = 16;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR0 = 3'd1,
    ST_HDR1 = 3'd2,
    ST_DATA = 3'd3,
    ST_CSUM = 3'd4,
    ST_DONE = 3'd5,
    ST_ERR  = 3'd6
  } state_t;

  // States in which the CPU is held and the byte stream is consumed.
  function automatic logic is_loading(state_t s);
    return (s == ST_HDR0) || (s == ST_HDR1) || (s == ST_DATA) || (s == ST_CSUM);
  endfunction

endpackage

// File: rtl/instr_mem_loader_if.sv
// Host byte stream plus instruction-RAM write port of the loader.
// master = host/test side, slave = loader.
interface instr_mem_loader_if import instr_loader_pkg::*;;

  // A byte moves on a rising clk edge where ByteValid & ByteReady are both 1;
  // the host holds ByteData stable while ByteValid is high and not yet accepted.
  logic              Start;
  logic              ByteValid;
  logic [BYTE_W-1:0] ByteData;
  logic              ByteReady;
  logic              MemWrEn;
  logic [WORD_W-1:0] MemAddr;
  logic [WORD_W-1:0] MemWrData;
  logic              CpuHold;
  logic              Done;
  logic              Error;

  modport master (
    output Start, ByteValid, ByteData,
    input  ByteReady, MemWrEn, MemAddr, MemWrData, CpuHold, Done, Error
  );

  modport slave (
    input  Start, ByteValid, ByteData,
    output ByteReady, MemWrEn, MemAddr, MemWrData, CpuHold, Done, Error
  );

endinterface

// File: rtl/instr_mem_loader_word_assembler.sv
// Packs four little-endian stream bytes into a 32-bit word; word_valid
// pulses combinationally with the strobe of the fourth byte.
module word_assembler import instr_loader_pkg::*; (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              strobe,
  input  logic [BYTE_W-1:0] byte_in,
  output logic              word_valid,
  output logic [WORD_W-1:0] word
);

  logic [1:0]               lane_q, lane_d;
  logic [WORD_W-BYTE_W-1:0] pack_q, pack_d;

  // Bytes shift in from the top so byte0 ends up in [7:0] after four strobes.
  always_comb begin
    lane_d = lane_q;
    pack_d = pack_q;
    if (clear) begin
      lane_d = '0;
      pack_d = '0;
    end else if (strobe) begin
      lane_d = lane_q + 2'd1;
      pack_d = {byte_in, pack_q[WORD_W-BYTE_W-1:BYTE_W]};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lane_q <= '0;
      pack_q <= '0;
    end else begin
      lane_q <= lane_d;
      pack_q <= pack_d;
    end
  end

  assign word_valid = strobe && !clear && (lane_q == 2'd3);
  assign word       = {byte_in, pack_q};

endmodule

// File: rtl/instr_mem_loader.sv
// Loads a length-prefixed byte-stream program image into instruction RAM.
// Define CHECKSUM_EN to require a trailing XOR checksum byte.
module instr_mem_loader import instr_loader_pkg::*; #(
  parameter int                DEPTH     = 256,
  parameter logic [WORD_W-1:0] BASE_ADDR = 32'h0
) (
  input  logic               clk,
  input  logic               reset,
  instr_mem_loader_if.slave  bus,
  output state_t             dbg_state
);

  localparam int IDX_W = $clog2(DEPTH) + 1;

  state_t            state_q, state_d;
  logic [HDR_W-1:0]  n_q, n_d, hdr_n;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              byte_ready_q, byte_ready_d;
  logic              mem_wr_en_q, mem_wr_en_d;
  logic [WORD_W-1:0] mem_addr_q, mem_addr_d;
  logic [WORD_W-1:0] mem_wr_data_q, mem_wr_data_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              xfer, start_ok, asm_strobe, word_valid;
  logic [WORD_W-1:0] word;
`ifdef CHECKSUM_EN
  logic [BYTE_W-1:0] csum_q, csum_d;
`endif

  assign xfer       = bus.ByteValid && byte_ready_q;
  assign start_ok   = bus.Start &&
                      ((state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR));
  assign asm_strobe = xfer && (state_q == ST_DATA);
  assign hdr_n      = {bus.ByteData, n_q[BYTE_W-1:0]};

  word_assembler u_asm (
    .clk        (clk),
    .reset      (reset),
    .clear      (start_ok),
    .strobe     (asm_strobe),
    .byte_in    (bus.ByteData),
    .word_valid (word_valid),
    .word       (word)
  );

  always_comb begin
    state_d       = state_q;
    n_d           = n_q;
    idx_d         = idx_q;
    mem_wr_en_d   = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_wr_data_d = mem_wr_data_q;
    done_d        = done_q;
    error_d       = error_q;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start_ok) begin
          state_d = ST_HDR0;
          idx_d   = '0;
          done_d  = 1'b0;
          error_d = 1'b0;
        end
      end
      ST_HDR0: begin
        if (xfer) begin
          n_d     = {{(HDR_W-BYTE_W){1'b0}}, bus.ByteData};
          state_d = ST_HDR1;
        end
      end
      ST_HDR1: begin
        if (xfer) begin
          n_d = hdr_n;
          if (hdr_n == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else if (int'(hdr_n) > DEPTH) begin
            state_d = ST_ERR;
            error_d = 1'b1;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (word_valid) begin
          mem_wr_en_d   = 1'b1;
          mem_addr_d    = BASE_ADDR + (WORD_W'(idx_q) << 2);
          mem_wr_data_d = word;
          idx_d         = idx_q + IDX_W'(1);
        end
        // Leave only after the last word's strobe cycle so CpuHold covers it.
        if (mem_wr_en_q && (HDR_W'(idx_q) == n_q)) begin
`ifdef CHECKSUM_EN
          state_d = ST_CSUM;
`else
          state_d = ST_DONE;
          done_d  = 1'b1;
`endif
        end
      end
`ifdef CHECKSUM_EN
      ST_CSUM: begin
        if (xfer) begin
          if (bus.ByteData == csum_q) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_ERR;
            error_d = 1'b1;
          end
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    cpu_hold_d   = is_loading(state_d);
    byte_ready_d = is_loading(state_d) && !mem_wr_en_d;
  end

`ifdef CHECKSUM_EN
  // XOR of every frame byte before the checksum itself, header included.
  always_comb begin
    csum_d = csum_q;
    if (start_ok) begin
      csum_d = '0;
    end else if (xfer && ((state_q == ST_HDR0) || (state_q == ST_HDR1) || (state_q == ST_DATA))) begin
      csum_d = csum_q ^ bus.ByteData;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      n_q           <= '0;
      idx_q         <= '0;
      byte_ready_q  <= 1'b0;
      mem_wr_en_q   <= 1'b0;
      mem_addr_q    <= BASE_ADDR;
      mem_wr_data_q <= '0;
      cpu_hold_q    <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
`ifdef CHECKSUM_EN
      csum_q        <= '0;
`endif
    end else begin
      state_q       <= state_d;
      n_q           <= n_d;
      idx_q         <= idx_d;
      byte_ready_q  <= byte_ready_d;
      mem_wr_en_q   <= mem_wr_en_d;
      mem_addr_q    <= mem_addr_d;
      mem_wr_data_q <= mem_wr_data_d;
      cpu_hold_q    <= cpu_hold_d;
      done_q        <= done_d;
      error_q       <= error_d;
`ifdef CHECKSUM_EN
      csum_q        <= csum_d;
`endif
    end
  end

  assign bus.ByteReady = byte_ready_q;
  assign bus.MemWrEn   = mem_wr_en_q;
  assign bus.MemAddr   = mem_addr_q;
  assign bus.MemWrData = mem_wr_data_q;
  assign bus.CpuHold   = cpu_hold_q;
  assign bus.Done      = done_q;
  assign bus.Error     = error_q;
  assign dbg_state     = state_q;

endmodule
